// File: rtl/alu_seq_param_if.sv
// Purpose: opcode request / result handshake between the instruction-decode board and the ALU.
// Latency: none, wires only.
// Backpressure: op_ready gates op_valid; res_valid is a one-cycle pulse with no result-side stall.
// Ports: master = decode board (drives op_valid/op_code/op_data, sees op_ready/res_valid/res_data);
//        slave  = ALU (the opposite directions).
interface alu_seq_param_if #(
    parameter int DATA_W = 4
) ();
    logic              op_valid;
    logic              op_ready;
    logic [4:0]        op_code;
    logic [DATA_W-1:0] op_data;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    modport master (
        output op_valid, op_code, op_data,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  op_valid, op_code, op_data,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/alu_seq_param.sv
// Purpose: parametrised sequential 4004-style accumulator ALU with acc/carry/mul-high/bank registers.
// Latency: single-cycle ops 1 cycle to res_valid; DAA DATA_W/4+1 cycles; MUL DATA_W+1 cycles.
// Backpressure: op_ready is high only in IDLE, so at most one op is in flight (one op per 2 cycles).
// Ports: sysclk/poc_n clock and async active-low clear; bus = op/result handshake (slave side);
//        acc_q, cy_q, mul_hi, acc_zero = architectural state; com_n in, cmram/cmrom bank selects out.
module alu_seq_param #(
    parameter int DATA_W    = 4,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                 sysclk,
    input  logic                 poc_n,
    alu_seq_param_if.slave       bus,
    output logic [DATA_W-1:0]    acc_q,
    output logic                 cy_q,
    output logic [DATA_W-1:0]    mul_hi,
    output logic                 acc_zero,
    input  logic                 com_n,
    output logic [NUM_BANKS-1:0] cmram,
    output logic                 cmrom
);
    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DAA_LAST = CNT_W'(NIB - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

    localparam logic [4:0] OP_LD  = 5'h01, OP_XCH = 5'h02, OP_ADD = 5'h03, OP_SUB = 5'h04,
                           OP_INC = 5'h05, OP_DEC = 5'h06, OP_RAL = 5'h07, OP_RAR = 5'h08,
                           OP_CMA = 5'h09, OP_CLC = 5'h0A, OP_STC = 5'h0B, OP_CMC = 5'h0C,
                           OP_IAC = 5'h0D, OP_TCS = 5'h0E, OP_KBP = 5'h0F, OP_DCL = 5'h10,
                           OP_DAA = 5'h11, OP_MUL = 5'h12;

    typedef enum logic [1:0] {IDLE, DAA_RUN, MUL_RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] acc, acc_nx, hi, hi_nx, res_q, res_nx, opd, opd_nx;
    logic              cy, cy_nx, dc, dc_nx;
    logic [BANK_W-1:0] bank, bank_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic [DATA_W:0]   s;
    logic [DATA_W:0]   addm;
    logic [3:0]        nib;
    logic [4:0]        t, sum5;
    logic              fix;

    // Keyboard-process: one-hot bit k -> k+1, zero -> zero, anything else -> all ones.
    function automatic logic [DATA_W-1:0] kbp(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '1;
        if (a == '0) begin
            r = '0;
        end else if ((a & (a - DATA_W'(1))) == '0) begin
            for (int k = 0; k < DATA_W; k++) begin
                if (a[k]) r = DATA_W'(k + 1);
            end
        end
        return r;
    endfunction

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            state <= IDLE;
            acc   <= '0;
            cy    <= 1'b0;
            hi    <= '0;
            bank  <= '0;
            res_q <= '0;
            opd   <= '0;
            dc    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cy    <= cy_nx;
            hi    <= hi_nx;
            bank  <= bank_nx;
            res_q <= res_nx;
            opd   <= opd_nx;
            dc    <= dc_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cy_nx    = cy;
        hi_nx    = hi;
        bank_nx  = bank;
        res_nx   = res_q;
        opd_nx   = opd;
        dc_nx    = dc;
        cnt_nx   = cnt;
        s        = '0;
        addm     = '0;
        nib      = '0;
        t        = '0;
        sum5     = '0;
        fix      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    opd_nx   = bus.op_data;
                    cnt_nx   = '0;
                    state_nx = DONE;
                    case (bus.op_code)
                        OP_LD, OP_XCH: acc_nx = bus.op_data;
                        OP_ADD: begin
                            s = {1'b0, acc} + {1'b0, bus.op_data} + {{DATA_W{1'b0}}, cy};
                            {cy_nx, acc_nx} = s;
                        end
                        // cy acts as not-borrow, so it is the carry-in of acc + ~d.
                        OP_SUB: begin
                            s = {1'b0, acc} + {1'b0, ~bus.op_data} + {{DATA_W{1'b0}}, cy};
                            {cy_nx, acc_nx} = s;
                        end
                        OP_INC: acc_nx = acc + DATA_W'(1);
                        OP_DEC: begin
                            s = {1'b0, acc} + {1'b0, {DATA_W{1'b1}}};
                            {cy_nx, acc_nx} = s;
                        end
                        OP_RAL: {cy_nx, acc_nx} = {acc, cy};
                        OP_RAR: {acc_nx, cy_nx} = {cy, acc};
                        OP_CMA: acc_nx = ~acc;
                        OP_CLC: cy_nx = 1'b0;
                        OP_STC: cy_nx = 1'b1;
                        OP_CMC: cy_nx = ~cy;
                        OP_IAC: begin
                            s = {1'b0, acc} + (DATA_W + 1)'(1);
                            {cy_nx, acc_nx} = s;
                        end
                        OP_TCS: begin
                            acc_nx = cy ? DATA_W'(10) : DATA_W'(9);
                            cy_nx  = 1'b0;
                        end
                        OP_KBP: acc_nx = kbp(acc);
                        OP_DCL: bank_nx = acc[BANK_W-1:0];
                        OP_DAA: begin
                            dc_nx    = cy;
                            state_nx = DAA_RUN;
                        end
                        OP_MUL: begin
                            hi_nx    = '0;
                            cy_nx    = 1'b0;
                            state_nx = MUL_RUN;
                        end
                        default: ;
                    endcase
                    res_nx = (bus.op_code == OP_XCH) ? acc : acc_nx;
                end
            end
            DAA_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (cnt == CNT_W'(i)) nib = acc[i*4 +: 4];
                end
                // Upper nibbles absorb the previous nibble's +6 overflow before their own check,
                // matching what adding 0x66.. to the whole word would do.
                t    = {1'b0, nib} + ((cnt != '0) ? {4'b0, dc} : 5'd0);
                fix  = (t > 5'd9) || dc;
                sum5 = t + (fix ? 5'd6 : 5'd0);
                for (int i = 0; i < NIB; i++) begin
                    if (cnt == CNT_W'(i)) acc_nx[i*4 +: 4] = sum5[3:0];
                end
                dc_nx  = sum5[4];
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == DAA_LAST) begin
                    if (sum5[4]) cy_nx = 1'b1;
                    res_nx   = acc_nx;
                    state_nx = DONE;
                end
            end
            MUL_RUN: begin
                // acc holds the unused multiplier bits and collects product low bits from the top.
                addm            = {1'b0, hi} + (acc[0] ? {1'b0, opd} : {(DATA_W + 1){1'b0}});
                {hi_nx, acc_nx} = {addm, acc[DATA_W-1:1]};
                cnt_nx          = cnt + CNT_W'(1);
                if (cnt == MUL_LAST) begin
                    res_nx   = acc_nx;
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            cmram[i] = ~com_n & (bank == BANK_W'(i));
        end
    end

    assign cmrom         = ~com_n & poc_n;
    assign bus.op_ready  = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_data  = res_q;
    assign acc_q         = acc;
    assign cy_q          = cy;
    assign mul_hi        = hi;
    assign acc_zero      = (acc == '0);
endmodule

// File: tb/tb_alu_seq_param.sv
// Purpose: scoreboard bench for alu_seq_param at DATA_W=4 and DATA_W=8.
// Latency: checks res_valid arrival cycle against the expected op latency.
// Backpressure: driver holds op_valid until op_ready is seen, so held requests during runs are exercised.
module tb_alu_seq_param;
    logic sysclk = 1'b0;
    logic poc_n;
    logic com_n;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    alu_seq_param_if #(.DATA_W(4)) if4 ();
    alu_seq_param_if #(.DATA_W(8)) if8 ();

    logic [3:0] acc4, hi4, cmram4;
    logic       cy4, z4, cmrom4;
    logic [7:0] acc8, hi8;
    logic [3:0] cmram8;
    logic       cy8, z8, cmrom8;

    alu_seq_param #(.DATA_W(4), .NUM_BANKS(4)) u4 (
        .sysclk(sysclk), .poc_n(poc_n), .bus(if4), .acc_q(acc4), .cy_q(cy4), .mul_hi(hi4),
        .acc_zero(z4), .com_n(com_n), .cmram(cmram4), .cmrom(cmrom4));
    alu_seq_param #(.DATA_W(8), .NUM_BANKS(4)) u8 (
        .sysclk(sysclk), .poc_n(poc_n), .bus(if8), .acc_q(acc8), .cy_q(cy8), .mul_hi(hi8),
        .acc_zero(z8), .com_n(com_n), .cmram(cmram8), .cmrom(cmrom8));

    typedef struct {
        string      tag;
        logic [7:0] res;
        logic [7:0] acc;
        logic       cy;
        logic [7:0] hi;
        int         lat;
        int         hs;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int total = 0;
    int bad   = 0;
    int spur  = 0;
    int nops  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one op and hold it until accepted; push the expectation at the handshake cycle.
    task automatic issue(input bit big, input logic [4:0] code, input logic [7:0] d, input bit push,
                         input logic [7:0] res, input logic [7:0] acc, input logic cy,
                         input logic [7:0] hi, input int lat);
        int   n;
        exp_t e;
        @(negedge sysclk);
        if (big) begin
            if8.op_valid = 1'b1; if8.op_code = code; if8.op_data = d;
        end else begin
            if4.op_valid = 1'b1; if4.op_code = code; if4.op_data = d[3:0];
        end
        n = 0;
        while (((big ? if8.op_ready : if4.op_ready) !== 1'b1) && n < 40) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 32'(n), 32'(0));
        nops++;
        if (push) begin
            e.tag = $sformatf("%s_op%0d_code%0h", big ? "w8" : "w4", nops, code);
            e.res = res; e.acc = acc; e.cy = cy; e.hi = hi; e.lat = lat; e.hs = cyc;
            if (big) q8.push_back(e);
            else     q4.push_back(e);
        end
        @(posedge sysclk);
    endtask

    task automatic idle();
        @(negedge sysclk);
        if4.op_valid = 1'b0;
        if8.op_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        chk("drain", 32'(q4.size() + q8.size()), 32'(0));
    endtask

    always @(negedge sysclk) begin
        if (if4.res_valid === 1'b1) begin
            if (q4.size() == 0) spur++;
            else begin
                e4 = q4.pop_front();
                chk({e4.tag, "_res"}, 32'(if4.res_data), 32'(e4.res));
                chk({e4.tag, "_acc"}, 32'(acc4), 32'(e4.acc));
                chk({e4.tag, "_cy"},  32'(cy4), 32'(e4.cy));
                chk({e4.tag, "_hi"},  32'(hi4), 32'(e4.hi));
                chk({e4.tag, "_zero"}, 32'(z4), 32'(e4.acc == 8'h00));
                chk({e4.tag, "_lat"}, 32'(cyc - e4.hs), 32'(e4.lat));
            end
        end
        if (if8.res_valid === 1'b1) begin
            if (q8.size() == 0) spur++;
            else begin
                e8 = q8.pop_front();
                chk({e8.tag, "_res"}, 32'(if8.res_data), 32'(e8.res));
                chk({e8.tag, "_acc"}, 32'(acc8), 32'(e8.acc));
                chk({e8.tag, "_cy"},  32'(cy8), 32'(e8.cy));
                chk({e8.tag, "_hi"},  32'(hi8), 32'(e8.hi));
                chk({e8.tag, "_lat"}, 32'(cyc - e8.hs), 32'(e8.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        poc_n = 1'b0;
        com_n = 1'b1;
        if4.op_valid = 1'b0; if4.op_code = '0; if4.op_data = '0;
        if8.op_valid = 1'b0; if8.op_code = '0; if8.op_data = '0;
        repeat (3) @(negedge sysclk);
        poc_n = 1'b1;
        @(negedge sysclk);
        chk("rst_acc4", 32'(acc4), 32'(0));
        chk("rst_cy4", 32'(cy4), 32'(0));
        chk("rst_hi4", 32'(hi4), 32'(0));
        chk("rst_rdy4", 32'(if4.op_ready), 32'(1));
        chk("rst_rv4", 32'(if4.res_valid), 32'(0));
        chk("rst_zero4", 32'(z4), 32'(1));
        chk("rst_cmram4", 32'(cmram4), 32'(0));
        chk("rst_cmrom4", 32'(cmrom4), 32'(0));
        chk("rst_acc8", 32'(acc8), 32'(0));

        //        big code   d      push res    acc    cy    hi     lat
        issue(0, 5'h01, 8'h9, 1, 8'h9, 8'h9, 1'b0, 8'h0, 1);  // LD 9
        issue(0, 5'h0B, 8'h0, 1, 8'h9, 8'h9, 1'b1, 8'h0, 1);  // STC
        issue(0, 5'h03, 8'h7, 1, 8'h1, 8'h1, 1'b1, 8'h0, 1);  // ADD 7 -> 17
        issue(0, 5'h01, 8'h3, 1, 8'h3, 8'h3, 1'b1, 8'h0, 1);  // LD 3
        issue(0, 5'h04, 8'h5, 1, 8'hE, 8'hE, 1'b0, 8'h0, 1);  // SUB 5 -> borrow
        issue(0, 5'h01, 8'h0, 1, 8'h0, 8'h0, 1'b0, 8'h0, 1);  // LD 0
        issue(0, 5'h06, 8'h0, 1, 8'hF, 8'hF, 1'b0, 8'h0, 1);  // DEC 0 -> F, cy 0
        issue(0, 5'h06, 8'h0, 1, 8'hE, 8'hE, 1'b1, 8'h0, 1);  // DEC F -> E, cy 1
        issue(0, 5'h02, 8'h5, 1, 8'hE, 8'h5, 1'b1, 8'h0, 1);  // XCH returns old acc
        issue(0, 5'h07, 8'h0, 1, 8'hB, 8'hB, 1'b0, 8'h0, 1);  // RAL
        issue(0, 5'h08, 8'h0, 1, 8'h5, 8'h5, 1'b1, 8'h0, 1);  // RAR
        issue(0, 5'h09, 8'h0, 1, 8'hA, 8'hA, 1'b1, 8'h0, 1);  // CMA
        issue(0, 5'h0C, 8'h0, 1, 8'hA, 8'hA, 1'b0, 8'h0, 1);  // CMC
        issue(0, 5'h0E, 8'h0, 1, 8'h9, 8'h9, 1'b0, 8'h0, 1);  // TCS cy=0 -> 9
        issue(0, 5'h0D, 8'h0, 1, 8'hA, 8'hA, 1'b0, 8'h0, 1);  // IAC
        issue(0, 5'h01, 8'hF, 1, 8'hF, 8'hF, 1'b0, 8'h0, 1);  // LD F
        issue(0, 5'h0D, 8'h0, 1, 8'h0, 8'h0, 1'b1, 8'h0, 1);  // IAC wraps, cy 1
        issue(0, 5'h05, 8'h0, 1, 8'h1, 8'h1, 1'b1, 8'h0, 1);  // INC keeps cy
        issue(0, 5'h0A, 8'h0, 1, 8'h1, 8'h1, 1'b0, 8'h0, 1);  // CLC
        issue(0, 5'h01, 8'h2, 1, 8'h2, 8'h2, 1'b0, 8'h0, 1);  // LD 2
        issue(0, 5'h10, 8'h0, 1, 8'h2, 8'h2, 1'b0, 8'h0, 1);  // DCL -> bank 2
        idle();
        drain();
        com_n = 1'b0;
        #1;
        chk("cmram4_bank2", 32'(cmram4), 32'(4'b0100));
        chk("cmrom4", 32'(cmrom4), 32'(1));
        chk("cmram8_bank0", 32'(cmram8), 32'(4'b0001));
        @(negedge sysclk);
        com_n = 1'b1;
        #1;
        chk("cmram4_off", 32'(cmram4), 32'(0));

        issue(0, 5'h01, 8'h4, 1, 8'h4, 8'h4, 1'b0, 8'h0, 1);  // LD 0100
        issue(0, 5'h0F, 8'h0, 1, 8'h3, 8'h3, 1'b0, 8'h0, 1);  // KBP -> 3
        issue(0, 5'h01, 8'h6, 1, 8'h6, 8'h6, 1'b0, 8'h0, 1);  // LD 0110
        issue(0, 5'h0F, 8'h0, 1, 8'hF, 8'hF, 1'b0, 8'h0, 1);  // KBP -> F
        issue(0, 5'h01, 8'h0, 1, 8'h0, 8'h0, 1'b0, 8'h0, 1);  // LD 0
        issue(0, 5'h0F, 8'h0, 1, 8'h0, 8'h0, 1'b0, 8'h0, 1);  // KBP -> 0
        issue(0, 5'h01, 8'hB, 1, 8'hB, 8'hB, 1'b0, 8'h0, 1);  // LD B
        issue(0, 5'h11, 8'h0, 1, 8'h1, 8'h1, 1'b1, 8'h0, 2);  // DAA -> 1, cy 1
        issue(0, 5'h0A, 8'h0, 1, 8'h1, 8'h1, 1'b0, 8'h0, 1);  // CLC
        issue(0, 5'h01, 8'hD, 1, 8'hD, 8'hD, 1'b0, 8'h0, 1);  // LD D
        issue(0, 5'h12, 8'hB, 1, 8'hF, 8'hF, 1'b0, 8'h8, 5);  // MUL B -> 143
        issue(0, 5'h00, 8'h3, 1, 8'hF, 8'hF, 1'b0, 8'h8, 1);  // NOP
        issue(0, 5'h1F, 8'h3, 1, 8'hF, 8'hF, 1'b0, 8'h8, 1);  // unused code
        issue(0, 5'h0C, 8'h0, 1, 8'hF, 8'hF, 1'b1, 8'h8, 1);  // CMC
        issue(0, 5'h12, 8'hF, 1, 8'h1, 8'h1, 1'b0, 8'hE, 5);  // MUL F*F -> E1, cy cleared
        idle();

        issue(1, 5'h01, 8'h9B, 1, 8'h9B, 8'h9B, 1'b0, 8'h00, 1);  // LD 9B
        issue(1, 5'h11, 8'h00, 1, 8'h01, 8'h01, 1'b1, 8'h00, 3);  // DAA -> 01, cy 1
        issue(1, 5'h0A, 8'h00, 1, 8'h01, 8'h01, 1'b0, 8'h00, 1);  // CLC
        issue(1, 5'h01, 8'h45, 1, 8'h45, 8'h45, 1'b0, 8'h00, 1);  // LD 45
        issue(1, 5'h11, 8'h00, 1, 8'h45, 8'h45, 1'b0, 8'h00, 3);  // DAA no change
        issue(1, 5'h0B, 8'h00, 1, 8'h45, 8'h45, 1'b1, 8'h00, 1);  // STC
        issue(1, 5'h11, 8'h00, 1, 8'h4B, 8'h4B, 1'b1, 8'h00, 3);  // DAA cy-in, cy kept
        issue(1, 5'h01, 8'hC8, 1, 8'hC8, 8'hC8, 1'b1, 8'h00, 1);  // LD 200
        issue(1, 5'h12, 8'hFA, 1, 8'h50, 8'h50, 1'b0, 8'hC3, 9);  // MUL 250 -> C350
        issue(1, 5'h01, 8'h80, 1, 8'h80, 8'h80, 1'b0, 8'hC3, 1);  // LD 80
        issue(1, 5'h0F, 8'h00, 1, 8'h08, 8'h08, 1'b0, 8'hC3, 1);  // KBP -> 8
        issue(1, 5'h01, 8'hF0, 1, 8'hF0, 8'hF0, 1'b0, 8'hC3, 1);  // LD F0
        issue(1, 5'h0B, 8'h00, 1, 8'hF0, 8'hF0, 1'b1, 8'hC3, 1);  // STC
        issue(1, 5'h03, 8'h0F, 1, 8'h00, 8'h00, 1'b1, 8'hC3, 1);  // ADD wraps to 0, cy 1
        idle();
        drain();

        // Reset in the middle of a MUL: no result may follow.
        issue(0, 5'h01, 8'h7, 1, 8'h7, 8'h7, 1'b0, 8'hE, 1);
        issue(0, 5'h12, 8'h3, 0, 8'h0, 8'h0, 1'b0, 8'h0, 0);
        idle();
        @(negedge sysclk);
        poc_n = 1'b0;
        #1;
        chk("midmul_rst_acc", 32'(acc4), 32'(0));
        chk("midmul_rst_cy", 32'(cy4), 32'(0));
        chk("midmul_rst_hi", 32'(hi4), 32'(0));
        chk("midmul_rst_rdy", 32'(if4.op_ready), 32'(1));
        @(negedge sysclk);
        poc_n = 1'b1;
        repeat (8) @(negedge sysclk);
        chk("midmul_rst_hi_after", 32'(hi4), 32'(0));
        issue(0, 5'h01, 8'h5, 1, 8'h5, 8'h5, 1'b0, 8'h0, 1);
        idle();
        drain();
        chk("spurious_res_valid", 32'(spur), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
